// File: rtl/lsu_byte_master_if.sv
// Core request/response and byte-wide RAM port bundle for lsu_byte_master.
// Latency: none, wires only.
// Backpressure: req_ready gates requests; the response and RAM sides have no stall.
// Ports: req_* (core request), trigger (MMIO level), resp_* (completion),
//        mem_* (single-byte RAM transactions, read data one cycle after issue).
interface lsu_byte_master_if #(
    parameter int AW = 17
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_mode;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          trigger;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    // Load/store unit view.
    modport master (
        input  req_valid, req_we, req_mode, req_addr, req_wdata, trigger, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Core + RAM environment view.
    modport slave (
        output req_valid, req_we, req_mode, req_addr, req_wdata, trigger, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_byte_master.sv
// Splits a word/half/byte load or store into big-endian single-byte RAM transactions.
// Latency: load N+2, store N+1 cycles (N = bytes); MMIO read or illegal mode 1 cycle.
// Backpressure: one request in flight, req_ready only in IDLE; response is a one-cycle pulse.
// Ports: clk, rst_n (async active-low); bus = lsu_byte_master_if.master
//        (req_* core request, trigger, resp_* completion, mem_* byte RAM port).
module lsu_byte_master #(
    parameter int          AW        = 17,
    parameter logic [31:0] MMIO_ADDR = 32'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lsu_byte_master_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [2:0]    mode_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [1:0]    cnt_q;
    logic [31:0]   shift_q;
    logic          rd_pend_q;
    logic          err_q;
    logic          mmio_q;

    logic          req_fire;
    logic          req_illegal;
    logic          req_mmio;
    logic [1:0]    last_cnt;
    logic [1:0]    byte_idx;

    function automatic logic mode_illegal(input logic [2:0] m);
        return (m == 3'b000) || (m == 3'b110) || (m == 3'b111);
    endfunction

    // Final value of cnt for the access size: N-1.
    function automatic logic [1:0] mode_last(input logic [2:0] m);
        case (m)
            3'b001:         return 2'd3;
            3'b010, 3'b100: return 2'd1;
            default:        return 2'd0;
        endcase
    endfunction

    assign req_fire    = (state_q == IDLE) && bus.req_valid;
    assign req_illegal = mode_illegal(bus.req_mode);
    assign req_mmio    = (bus.req_addr == MMIO_ADDR);
    assign last_cnt    = mode_last(mode_q);
    // First beat carries the most significant byte of the sized value.
    assign byte_idx    = last_cnt - cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mode_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            mmio_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Read data returns one cycle after issue, so capture lags XFER by one.
            rd_pend_q <= (state_q == XFER) && !we_q;
            if (rd_pend_q) begin
                shift_q <= {shift_q[23:0], bus.mem_rdata};
            end
            if (state_q == XFER) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (req_fire) begin
                addr_q  <= bus.req_addr[AW-1:0];
                mode_q  <= bus.req_mode;
                we_q    <= bus.req_we;
                wdata_q <= bus.req_wdata;
                cnt_q   <= '0;
                err_q   <= req_illegal;
                mmio_q  <= req_mmio && !req_illegal;
                // MMIO reads answer from the trigger level seen at acceptance.
                shift_q <= {31'b0, bus.trigger && req_mmio};
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready   = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_err    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = (req_illegal || req_mmio) ? RESP : XFER;
                end
            end
            XFER: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q + AW'(cnt_q);
                bus.mem_wdata = wdata_q[{byte_idx, 3'b000} +: 8];
                if (cnt_q == last_cnt) begin
                    state_d = we_q ? RESP : DRAIN;
                end
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                if (!err_q && !we_q) begin
                    if (mmio_q) begin
                        bus.resp_rdata = shift_q;
                    end else begin
                        case (mode_q)
                            3'b010:  bus.resp_rdata = {{16{shift_q[15]}}, shift_q[15:0]};
                            3'b100:  bus.resp_rdata = {16'b0, shift_q[15:0]};
                            3'b011:  bus.resp_rdata = {{24{shift_q[7]}}, shift_q[7:0]};
                            3'b101:  bus.resp_rdata = {24'b0, shift_q[7:0]};
                            default: bus.resp_rdata = shift_q;
                        endcase
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
module tb_lsu_byte_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_byte_master_if #(.AW(17)) bus ();

    lsu_byte_master #(.AW(17), .MMIO_ADDR(32'h100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Byte RAM environment.
    logic [7:0] ram [0:131071];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : 8'h00;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: expectations scheduled by cycle number at acceptance time.
    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wdata;
    } mem_exp_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_exp_t;

    mem_exp_t  exp_mem  [int];
    resp_exp_t exp_resp [int];
    int        busy_until = 0;
    int        acc_log [$];
    int        resp_log [$];
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic model_accept(input int c, input logic we, input logic [2:0] mode,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic trig);
        int          nb;
        int          lat;
        logic [31:0] val;
        logic [31:0] sh;
        logic [16:0] a;
        resp_exp_t   r;
        case (mode)
            3'd1:       nb = 4;
            3'd2, 3'd4: nb = 2;
            3'd3, 3'd5: nb = 1;
            default:    nb = 0;
        endcase
        val = 32'h0;
        r   = '0;
        if (nb == 0) begin
            lat   = 1;
            r.err = 1'b1;
        end else if (addr == 32'h100) begin
            lat     = 1;
            r.rdata = we ? 32'h0 : {31'b0, trig};
        end else begin
            for (int i = 0; i < nb; i++) begin
                a  = 17'(addr + 32'(i));
                sh = wdata >> (8 * (nb - 1 - i));
                exp_mem[c + 1 + i] = '{we: we, addr: a, wdata: sh[7:0]};
                val = (val << 8) | {24'h0, ram[a]};
            end
            if (mode == 3'd2) val = {{16{val[15]}}, val[15:0]};
            if (mode == 3'd3) val = {{24{val[7]}}, val[7:0]};
            lat     = we ? nb + 1 : nb + 2;
            r.rdata = we ? 32'h0 : val;
        end
        exp_resp[c + lat] = r;
        busy_until = c + lat + 1;
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_mem", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
            check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
            exp_mem.delete();
            exp_resp.delete();
            busy_until = 0;
        end else begin
            check("req_ready", {31'b0, bus.req_ready}, {31'b0, (cyc >= busy_until)});
            if (exp_mem.exists(cyc)) begin
                check("mem_en", {31'b0, bus.mem_en}, 32'h1);
                check("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_mem[cyc].we});
                check("mem_addr", {15'b0, bus.mem_addr}, {15'b0, exp_mem[cyc].addr});
                if (exp_mem[cyc].we)
                    check("mem_wdata", {24'b0, bus.mem_wdata}, {24'b0, exp_mem[cyc].wdata});
                exp_mem.delete(cyc);
            end else begin
                check("mem_idle", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
            end
            if (exp_resp.exists(cyc)) begin
                check("resp_valid", {31'b0, bus.resp_valid}, 32'h1);
                check("resp_rdata", bus.resp_rdata, exp_resp[cyc].rdata);
                check("resp_err", {31'b0, bus.resp_err}, {31'b0, exp_resp[cyc].err});
                exp_resp.delete(cyc);
            end else begin
                check("resp_quiet", {31'b0, bus.resp_valid}, 32'h0);
            end
            if (bus.resp_valid) begin
                resp_log.push_back(cyc);
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_log.push_back(cyc);
                model_accept(cyc, bus.req_we, bus.req_mode, bus.req_addr,
                             bus.req_wdata, bus.trigger);
            end
        end
    end

    // Waits (bounded) for a negedge with req_ready high.
    task automatic wait_ready(input string name);
        bit got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check({name, "_accept_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic issue(input logic we, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata, input string name);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_mode  = mode;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        wait_ready(name);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0BAD_0BAD;
    endtask

    // Issue one request, let it finish, then pin result and latency with literals.
    task automatic run(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat, input string name);
        int n0 = resp_log.size();
        issue(we, mode, addr, wdata, name);
        repeat (8) @(posedge clk);
        #1;
        check({name, "_resp_count"}, 32'(resp_log.size() - n0), 32'h1);
        check({name, "_rdata"}, last_rdata, exp_rdata);
        check({name, "_err"}, {31'b0, last_err}, {31'b0, exp_err});
        check({name, "_latency"}, 32'(resp_log[$] - acc_log[$]), 32'(exp_lat));
    endtask

    initial begin
        int n_acc;
        int n_resp;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_mode  = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.trigger   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_en", {31'b0, bus.mem_en}, 32'h0);
        check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", {31'b0, bus.req_ready}, 32'h1);

        // Word store, MSB at lowest address.
        run(1'b1, 3'b001, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 5, "st_word");
        check("st_word_b0", {24'h0, ram[17'h40]}, 32'hDE);
        check("st_word_b1", {24'h0, ram[17'h41]}, 32'hAD);
        check("st_word_b2", {24'h0, ram[17'h42]}, 32'hBE);
        check("st_word_b3", {24'h0, ram[17'h43]}, 32'hEF);

        // Half store uses only the low 16 bits of wdata.
        run(1'b1, 3'b010, 32'h80, 32'h9999F321, 32'h0, 1'b0, 3, "st_half");
        check("st_half_b0", {24'h0, ram[17'h80]}, 32'hF3);
        check("st_half_b1", {24'h0, ram[17'h81]}, 32'h21);

        run(1'b0, 3'b010, 32'h80, 32'h0, 32'hFFFFF321, 1'b0, 4, "ld_half_s");
        run(1'b0, 3'b100, 32'h80, 32'h0, 32'h0000F321, 1'b0, 4, "ld_half_u");
        run(1'b0, 3'b011, 32'h81, 32'h0, 32'h00000021, 1'b0, 3, "ld_byte_s");
        run(1'b0, 3'b011, 32'h80, 32'h0, 32'hFFFFFFF3, 1'b0, 3, "ld_byte_neg");
        run(1'b0, 3'b101, 32'h80, 32'h0, 32'h000000F3, 1'b0, 3, "ld_byte_u");

        // Byte store and wrap-around word access at the top of RAM.
        run(1'b1, 3'b011, 32'h50, 32'h123456AB, 32'h0, 1'b0, 2, "st_byte");
        check("st_byte_b0", {24'h0, ram[17'h50]}, 32'hAB);
        run(1'b1, 3'b001, 32'h1FFFE, 32'h11223344, 32'h0, 1'b0, 5, "st_wrap");
        check("st_wrap_b2", {24'h0, ram[17'h0]}, 32'h33);
        run(1'b0, 3'b001, 32'h1FFFE, 32'h0, 32'h11223344, 1'b0, 6, "ld_wrap");

        // MMIO trigger address and illegal modes.
        bus.trigger = 1'b1;
        run(1'b0, 3'b001, 32'h100, 32'h0, 32'h00000001, 1'b0, 1, "mmio_ld1");
        bus.trigger = 1'b0;
        run(1'b0, 3'b001, 32'h100, 32'h0, 32'h00000000, 1'b0, 1, "mmio_ld0");
        run(1'b1, 3'b001, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b0, 1, "mmio_st");
        run(1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 1'b1, 1, "err_110");
        run(1'b1, 3'b000, 32'h40, 32'h0, 32'h0, 1'b1, 1, "err_000");
        check("err_no_write", {24'h0, ram[17'h40]}, 32'hDE);

        // Reset during the third XFER beat of a word store.
        run(1'b1, 3'b001, 32'h60, 32'h0, 32'h0, 1'b0, 5, "st_clear");
        n_resp = resp_log.size();
        issue(1'b1, 3'b001, 32'h60, 32'hCAFEF00D, "abort");
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort_pre_we", {31'b0, bus.mem_we}, 32'h1);
        check("abort_pre_addr", {15'b0, bus.mem_addr}, 32'h62);
        rst_n = 1'b0;
        #1;
        check("abort_mem_en", {31'b0, bus.mem_en}, 32'h0);
        check("abort_mem_we", {31'b0, bus.mem_we}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort_ready", {31'b0, bus.req_ready}, 32'h1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_resp", 32'(resp_log.size() - n_resp), 32'h0);
        check("abort_b0", {24'h0, ram[17'h60]}, 32'hCA);
        check("abort_b1", {24'h0, ram[17'h61]}, 32'hFE);
        check("abort_b2", {24'h0, ram[17'h62]}, 32'h00);

        // Back-to-back: second request held valid while the first runs.
        n_acc  = acc_log.size();
        n_resp = resp_log.size();
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_mode  = 3'b001;
        bus.req_addr  = 32'h200;
        bus.req_wdata = 32'hA1B2C3D4;
        wait_ready("b2b_first");
        @(posedge clk); #1;
        bus.req_addr  = 32'h204;
        bus.req_wdata = 32'h55667788;
        wait_ready("b2b_second");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("b2b_acc_count", 32'(acc_log.size() - n_acc), 32'h2);
        check("b2b_gap", 32'(acc_log[n_acc + 1] - resp_log[n_resp]), 32'h1);
        check("b2b_b0", {24'h0, ram[17'h200]}, 32'hA1);
        check("b2b_b1", {24'h0, ram[17'h201]}, 32'hB2);
        check("b2b_b2", {24'h0, ram[17'h202]}, 32'hC3);
        check("b2b_b3", {24'h0, ram[17'h203]}, 32'hD4);
        check("b2b_second_b0", {24'h0, ram[17'h204]}, 32'h55);
        check("b2b_second_b3", {24'h0, ram[17'h207]}, 32'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
